// File: rtl/weight_buffer_bank.sv
// Per-filter weight bank: two-element write beats steered by a one-hot filter
// select, then lockstep circular streaming of every filter to the conv engine.
module weight_buffer_bank #(
  parameter int NUM_FILT = 32,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 32
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clear,
  input  logic [5:0]                 weight_dim,
  input  logic [5:0]                 num_filt,
  input  logic [NUM_FILT-1:0]        weight_en,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [2*DATA_W-1:0]        wr_data,
  input  logic [1:0]                 wr_keep,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [NUM_FILT*DATA_W-1:0] rd_data,
  output logic                       rd_last,
  output logic [NUM_FILT-1:0]        filt_loaded,
  output logic                       all_loaded,
  output logic                       err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam logic [6:0] DEPTH_L = 7'(DEPTH);
  localparam logic [6:0] NFILT_L = 7'(NUM_FILT);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0]          r_mem [NUM_FILT][DEPTH];
  logic [5:0]                 r_cnt [NUM_FILT];
  logic [5:0]                 r_dim_q, r_nf_q, r_rd_ptr;
  logic [NUM_FILT-1:0]        r_filt_loaded;
  logic                       r_all_loaded, r_err, r_rd_valid, r_rd_last;
  logic [NUM_FILT*DATA_W-1:0] r_rd_data;

  logic [5:0]          w_dim, w_nf, w_cnt_sel, w_rem, w_cnt_nxt;
  logic [SW-1:0]       w_sel;
  logic [NUM_FILT-1:0] w_mask;
  logic [AW-1:0]       w_idx0, w_idx1;
  logic w_onehot, w_keep_ok, w_cfg_ok, w_start, w_xfer, w_two, w_ovf;
  logic w_err_set, w_all_req, w_rd;

  // Before the first beat the live configuration stands in for the latched one.
  assign w_dim = (r_state == IDLE) ? weight_dim : r_dim_q;
  assign w_nf  = (r_state == IDLE) ? num_filt   : r_nf_q;
  assign w_cfg_ok = (w_dim != 6'd0) && ({1'b0, w_dim} <= DEPTH_L) &&
                    (w_nf != 6'd0) && ({1'b0, w_nf} <= NFILT_L);

  assign w_onehot  = (weight_en != '0) &&
                     ((weight_en & (weight_en - NUM_FILT'(1))) == '0);
  assign w_keep_ok = wr_keep[0];

  always_comb begin
    w_sel  = '0;
    w_mask = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      if (weight_en[f]) w_sel = SW'(f);
      w_mask[f] = (7'(f) < {1'b0, r_nf_q});
    end
  end

  assign w_cnt_sel = r_cnt[w_sel];
  assign w_rem     = w_dim - w_cnt_sel;
  assign w_xfer    = wr_valid && wr_ready;
  assign w_two     = w_xfer && wr_keep[1] && (w_rem >= 6'd2);
  assign w_ovf     = w_xfer && wr_keep[1] && (w_rem == 6'd1);
  assign w_cnt_nxt = w_cnt_sel + (w_two ? 6'd2 : 6'd1);
  assign w_idx0    = w_cnt_sel[AW-1:0];
  assign w_idx1    = w_idx0 + AW'(1);

  assign w_start   = (r_state == IDLE) && wr_valid && (weight_en != '0);
  assign w_err_set = (r_state != STREAM) && wr_valid && (weight_en != '0) &&
                     (!w_cfg_ok || !w_onehot || !w_keep_ok || w_ovf);
  assign w_all_req = w_cfg_ok && (&(r_filt_loaded | ~w_mask));
  assign w_rd      = (r_state == STREAM) && rd_en;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = LOAD;
      LOAD:    if (w_all_req) w_state_nxt = STREAM;
      STREAM:  w_state_nxt = STREAM;
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  always_comb begin
    wr_ready = nrst && !clear && (r_state != STREAM) && w_onehot &&
               !r_filt_loaded[w_sel] && w_cfg_ok && w_keep_ok;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_dim_q <= '0; r_nf_q <= '0; r_rd_ptr <= '0;
      r_filt_loaded <= '0; r_all_loaded <= 1'b0; r_err <= 1'b0;
      r_rd_valid <= 1'b0; r_rd_last <= 1'b0;
      for (int f = 0; f < NUM_FILT; f++) r_cnt[f] <= '0;
    end else if (clear) begin
      r_dim_q <= '0; r_nf_q <= '0; r_rd_ptr <= '0;
      r_filt_loaded <= '0; r_all_loaded <= 1'b0; r_err <= 1'b0;
      r_rd_valid <= 1'b0; r_rd_last <= 1'b0;
      for (int f = 0; f < NUM_FILT; f++) r_cnt[f] <= '0;
    end else begin
      if (w_start) begin
        r_dim_q <= weight_dim;
        r_nf_q  <= num_filt;
      end
      if (w_xfer) begin
        r_cnt[w_sel] <= w_cnt_nxt;
        if (w_cnt_nxt == w_dim) r_filt_loaded[w_sel] <= 1'b1;
      end
      if (w_err_set) r_err <= 1'b1;
      if ((r_state == LOAD) && w_all_req) r_all_loaded <= 1'b1;
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_last <= (r_rd_ptr == r_dim_q - 6'd1);
        r_rd_ptr  <= (r_rd_ptr == r_dim_q - 6'd1) ? 6'd0 : r_rd_ptr + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mem[w_sel][w_idx0] <= wr_data[DATA_W-1:0];
      if (w_two) r_mem[w_sel][w_idx1] <= wr_data[2*DATA_W-1:DATA_W];
    end
  end

  // Read stage: one element of every active filter, registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_rd_data <= '0;
    else if (clear) r_rd_data <= '0;
    else if (w_rd) begin
      for (int f = 0; f < NUM_FILT; f++)
        r_rd_data[f*DATA_W +: DATA_W] <= w_mask[f] ? r_mem[f][r_rd_ptr[AW-1:0]] : '0;
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_last     = r_rd_last;
  assign filt_loaded = r_filt_loaded;
  assign all_loaded  = r_all_loaded;
  assign err         = r_err;
endmodule

// File: tb/tb_weight_buffer_bank.sv
// Directed bench for weight_buffer_bank: load, stream, wrap, clear, overflow,
// illegal beats and asynchronous reset mid-load.
module tb_weight_buffer_bank;
  localparam int NF = 32;
  localparam int DW = 16;
  localparam int DP = 32;

  logic clk = 1'b0;
  logic nrst, clear, wr_valid, wr_ready, rd_en, rd_valid, rd_last, all_loaded, err;
  logic [5:0] weight_dim, num_filt;
  logic [NF-1:0] weight_en, filt_loaded;
  logic [2*DW-1:0] wr_data;
  logic [1:0] wr_keep;
  logic [NF*DW-1:0] rd_data;

  int n_chk = 0;
  int n_bad = 0;

  weight_buffer_bank #(.NUM_FILT(NF), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .weight_dim(weight_dim),
    .num_filt(num_filt), .weight_en(weight_en), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_keep(wr_keep), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .filt_loaded(filt_loaded), .all_loaded(all_loaded), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sl(input int f);
    return rd_data[f*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int f, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                      input logic [1:0] keep);
    weight_en = 32'(1) << f;
    wr_data   = {hi, lo};
    wr_keep   = keep;
    wr_valid  = 1'b1;
    step();
    wr_valid  = 1'b0;
    weight_en = '0;
  endtask

  task automatic load(input int f, input int base, input int dim);
    for (int i = 0; i < dim; i += 2) begin
      if (i + 1 < dim) beat(f, DW'(base + i), DW'(base + i + 1), 2'b11);
      else             beat(f, DW'(base + i), '0, 2'b01);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    nrst = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    weight_en = '0; wr_data = '0; wr_keep = 2'b11;
    weight_dim = 6'd9; num_filt = 6'd2;
    #2 nrst = 1'b0;
    #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_all_loaded", all_loaded, 0);
    check("rst_filt_loaded", filt_loaded, 0);
    check("rst_err", err, 0);
    check("rst_rd_data", rd_data == '0, 1);
    step(); step();
    nrst = 1'b1;

    // dim 9, two filters
    weight_en = 32'h1; #1;
    check("idle_ready", wr_ready, 1);
    weight_en = '0; wr_valid = 1'b1; #1;
    check("en0_ready", wr_ready, 0);
    step();
    wr_valid = 1'b0;
    check("en0_no_err", err, 0);
    load(0, 1, 9);
    check("f0_loaded", filt_loaded, 32'h1);
    weight_en = 32'h1; wr_keep = 2'b11; #1;
    check("f0_full_ready", wr_ready, 0);
    weight_en = '0;
    load(1, 11, 9);
    check("both_loaded", filt_loaded, 32'h3);
    check("all_not_yet", all_loaded, 0);
    rd_en = 1'b1;
    step();
    check("all_loaded", all_loaded, 1);
    check("rd_ignored_rise", rd_valid, 0);
    weight_en = 32'h4; #1;
    check("stream_ready", wr_ready, 0);
    weight_en = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("rd_valid", rd_valid, 1);
      check("s0", sl(0), 64'(k % 9 + 1));
      check("s1", sl(1), 64'(k % 9 + 11));
      check("rd_last", rd_last, (k % 9) == 8);
      check("upper_zero", |rd_data[NF*DW-1:2*DW], 0);
    end
    rd_en = 1'b0;
    step();
    check("rd_valid_drop", rd_valid, 0);
    check("rd_hold", sl(0), 2);
    rd_en = 1'b1;
    step();
    check("rd_resume", sl(0), 3);
    check("err_clean", err, 0);

    // clear mid-stream with rd_en high
    pulse_clear();
    check("clr_rd_valid", rd_valid, 0);
    check("clr_all_loaded", all_loaded, 0);
    check("clr_filt_loaded", filt_loaded, 0);
    check("clr_rd_data", rd_data == '0, 1);
    rd_en = 1'b0;
    weight_dim = 6'd25; num_filt = 6'd1;
    load(0, 100, 25);
    check("d25_loaded", filt_loaded, 32'h1);
    check("d25_all_not_yet", all_loaded, 0);
    step();
    check("d25_all", all_loaded, 1);
    rd_en = 1'b1;
    for (int k = 0; k < 26; k++) begin
      step();
      check("d25_s0", sl(0), 64'(100 + k % 25));
      check("d25_last", rd_last, (k % 25) == 24);
    end
    check("d25_upper_zero", |rd_data[NF*DW-1:DW], 0);
    rd_en = 1'b0;

    // overflow: dim 3, last beat keep 11 with one slot left
    pulse_clear();
    weight_dim = 6'd3; num_filt = 6'd1;
    beat(0, 16'd1, 16'd2, 2'b11);
    check("ovf_err_before", err, 0);
    check("ovf_fl_before", filt_loaded, 0);
    beat(0, 16'd3, 16'd4, 2'b11);
    check("ovf_err", err, 1);
    check("ovf_fl", filt_loaded, 32'h1);
    step();
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ovf_s0", sl(0), 64'(k % 3 + 1));
      check("ovf_last", rd_last, (k % 3) == 2);
    end
    rd_en = 1'b0;

    // illegal select and illegal keep
    pulse_clear();
    check("clr_err", err, 0);
    weight_dim = 6'd9; num_filt = 6'd2;
    weight_en = 32'h3; wr_keep = 2'b11; wr_data = 32'hdead_beef; wr_valid = 1'b1; #1;
    check("multi_ready", wr_ready, 0);
    step();
    check("multi_err", err, 1);
    weight_en = 32'h1; wr_keep = 2'b10; #1;
    check("keep10_ready", wr_ready, 0);
    step();
    wr_valid = 1'b0; weight_en = '0;
    check("keep10_err", err, 1);
    for (int i = 0; i < 4; i++) beat(0, DW'(2*i + 1), DW'(2*i + 2), 2'b11);
    check("ill_fl_partial", filt_loaded, 0);
    beat(0, 16'd9, 16'd0, 2'b01);
    check("ill_fl_done", filt_loaded, 32'h1);
    load(1, 11, 9);
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("ill_s0", sl(0), 1);
    check("ill_s1", sl(1), 11);

    // asynchronous reset mid-load (filter 3, cnt 4)
    pulse_clear();
    weight_dim = 6'd25; num_filt = 6'd4;
    beat(3, 16'd51, 16'd52, 2'b11);
    beat(3, 16'd53, 16'd54, 2'b11);
    weight_en = 32'h8; wr_keep = 2'b11;
    #1 nrst = 1'b0;
    #1;
    check("arst_wr_ready", wr_ready, 0);
    check("arst_filt", filt_loaded, 0);
    check("arst_err", err, 0);
    check("arst_rd_valid", rd_valid, 0);
    weight_en = '0;
    step();
    nrst = 1'b1;
    weight_dim = 6'd5;
    beat(3, 16'd60, 16'd61, 2'b11);
    beat(3, 16'd62, 16'd63, 2'b11);
    check("arst_f3_partial", filt_loaded, 0);
    beat(3, 16'd64, 16'd0, 2'b01);
    check("arst_f3_done", filt_loaded, 32'h8);
    check("arst_no_err", err, 0);
    load(0, 70, 5);
    load(1, 80, 5);
    load(2, 90, 5);
    step();
    check("arst_all", all_loaded, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("arst_s3", sl(3), 60);
    check("arst_s0", sl(0), 70);
    check("arst_s2", sl(2), 90);
    check("arst_upper_zero", |rd_data[NF*DW-1:4*DW], 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/weight_buffer_bank.md
Name: weight_buffer_bank

Overview:
- Per-filter weight storage bank on the receiving end of the CNN controller's one-hot `weight_en` lines.
- Accepts weight elements from the AXI-side loader at two elements per clock and writes them into the filter slot selected by `weight_en`.
- Once every configured filter is loaded, streams the weights to the conv engine in lockstep: one element of every filter per read, with the element index wrapping circularly so kernels are reused across image windows.

Parameters:
- NUM_FILT, 32, number of filter slots; width of `weight_en`.
- DATA_W, 16, bits per weight element.
- DEPTH, 32, maximum elements per filter; must be ≥ 25 for a 5x5 kernel.

Ports:
- clk  in  1  clock
- nrst  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous flush, pulsed by the controller in its out state
- weight_dim  in  6  elements per filter (legal range 1..DEPTH)
- num_filt  in  6  filters in use (legal range 1..NUM_FILT)
- weight_en  in  NUM_FILT  one-hot filter select for writes
- wr_valid  in  1  write beat valid
- wr_ready  out  1  bank accepts the beat
- wr_data  in  2*DATA_W  two elements; [DATA_W-1:0] is written first
- wr_keep  in  2  2'b11 = both elements valid, 2'b01 = low element only
- rd_en  in  1  read request from the conv engine
- rd_valid  out  1  rd_data valid
- rd_data  out  NUM_FILT*DATA_W  element rd_ptr of every filter; filter f occupies slice f
- rd_last  out  1  the returned element is index weight_dim-1
- filt_loaded  out  NUM_FILT  per-filter load complete
- all_loaded  out  1  filters 0..num_filt-1 are all loaded
- err  out  1  sticky protocol error

Behaviour:
- Reset (nrst low, async) and clear (sync; overrides every other input that cycle):
  - All outputs go to 0; per-filter counters, rd_ptr and state are zeroed; state = IDLE.
  - Storage contents are not cleared; their values are don't-care.
- State machine:
  - IDLE → LOAD on the first cycle with wr_valid=1 and nonzero weight_en. weight_dim and num_filt are latched on that edge and held until the next clear or reset.
  - LOAD → STREAM on the cycle after the last required filter reaches cnt = dim_q; all_loaded rises on that same edge.
  - STREAM holds until clear or reset.
- Latched configuration check:
  - dim_q = 0, dim_q > DEPTH, nf_q = 0 or nf_q > NUM_FILT: set err, hold wr_ready = 0, and never leave LOAD.
- Write acceptance:
  - wr_ready = (state is IDLE or LOAD) AND weight_en is one-hot AND !filt_loaded[sel] AND the latched configuration is legal. In IDLE, configuration legality is evaluated on the live inputs.
  - A beat transfers when wr_valid && wr_ready.
  - Element writes: low element goes to mem[sel][cnt[sel]]; if wr_keep = 11, the high element goes to mem[sel][cnt[sel]+1]. cnt[sel] advances by 1 or 2.
  - Overflow: if wr_keep = 11 but only one slot remains, only the low element is stored and err is set.
  - filt_loaded[sel] sets on the edge where cnt[sel] reaches dim_q.
  - Writes to a filter index ≥ nf_q are accepted and stored, but do not count toward all_loaded.
- Illegal write inputs (err set, beat not accepted, wr_ready = 0):
  - weight_en with more than one bit set while wr_valid = 1.
  - wr_keep = 00 or 10 with wr_valid = 1.
  - weight_en = 0 gives wr_ready = 0 with no error.
- Switching filters: when the controller moves from filter i to i+1, writing resumes at cnt[i+1]. A partially loaded filter may be revisited later.
- Read path (STREAM only; latency 1):
  - rd_en in cycle t → rd_valid = 1 in cycle t+1.
  - rd_data slice f = mem[f][rd_ptr] for f < nf_q; slices for f ≥ nf_q are 0.
  - rd_last = (rd_ptr == dim_q-1).
  - rd_ptr increments and wraps from dim_q-1 to 0; dim_q = 1 returns index 0 every read with rd_last = 1.
  - rd_valid drops the cycle after rd_en deasserts; rd_data holds its last value.
  - rd_en outside STREAM is ignored, including the cycle in which all_loaded is rising.
- Reset mid-load or mid-stream: full flush; the next load restarts from IDLE.
- Arithmetic: cnt is 6 bits and is never driven past dim_q.

Test Plan:
- weight_dim=9, num_filt=2: filter 0 loaded with keep 11,11,11,11,01 holding values 1..9, then filter 1 with 11..19 → filt_loaded=2'b11; all_loaded=1 one cycle after the final beat; wr_ready=0 from then on.
- After the load above, hold rd_en for 20 cycles → slice0 returns 1..9,1..9,1,2 and slice1 returns 11..19,…; rd_last on reads 9 and 18; slices 2..31 = 0.
- weight_dim=3, one slot left, keep=11 → only the low element is stored; err=1; filt_loaded[0]=1.
- weight_en=32'h3 with wr_valid → wr_ready=0, no write, err=1; then keep=10 on a legal select → not accepted; err stays 1.
- clear pulsed mid-STREAM while rd_en is high → rd_valid=0 the next cycle; state IDLE; all_loaded=0; rd_ptr=0; a fresh load with weight_dim=25 behaves as a first load.
- nrst asserted mid-LOAD (filter 3, cnt=4) → all outputs 0 immediately; the next load writes filter 3 starting at cnt=0.
